// File: rtl/fft16_sample_loader_if.sv
// Stream-in / frame-out bundle for the FFT input framing stage.
// The slave modport is the loader itself. The master modport is the logic around it,
// which sources samples and consumes frames.
interface fft16_sample_loader_if #(
    parameter int WIDTH = 16
);
    // sample stream into the loader
    logic                    s_valid;
    logic                    s_ready;
    logic signed [WIDTH-1:0] s_x;
    logic signed [WIDTH-1:0] s_y;
    logic                    s_last;

    // frame presented to the FFT, sample k at [WIDTH*k +: WIDTH]
    logic                    m_valid;
    logic                    m_ready;
    logic [16*WIDTH-1:0]     m_x;
    logic [16*WIDTH-1:0]     m_y;

    // status
    logic                    frame_err;
    logic [7:0]              frame_cnt;

    modport slave (
        input  s_valid, s_x, s_y, s_last, m_ready,
        output s_ready, m_valid, m_x, m_y, frame_err, frame_cnt
    );

    modport master (
        output s_valid, s_x, s_y, s_last, m_ready,
        input  s_ready, m_valid, m_x, m_y, frame_err, frame_cnt
    );
endinterface

// File: rtl/fft16_sample_loader.sv
// Ping-pong framing buffer in front of the 16-point FFT.
// Samples fill one bank while the other bank is held on m_x/m_y for the FFT.
// Data is stored and presented bit-exact. No arithmetic is applied to it.
module fft16_sample_loader #(
    parameter int WIDTH = 16
) (
    input  logic                 clock,
    input  logic                 reset_n,
    fft16_sample_loader_if.slave bus
);
    localparam int N = 16;

    // control state
    logic       wr_bank;
    logic       rd_bank;
    logic [1:0] full;
    logic [1:0] full_nxt;
    logic [3:0] wr_idx;
    logic [7:0] frame_cnt_q;
    logic       frame_err_q;

    // two banks per component, indexed [bank][sample]
    logic signed [WIDTH-1:0] bank_x [2][N];
    logic signed [WIDTH-1:0] bank_y [2][N];

    logic accept;
    logic handoff;
    logic frame_done;
    logic short_frame;
    logic long_frame;

    // s_ready and m_valid come only from registered state.
    // This keeps m_ready off any combinational path to s_ready.
    assign bus.s_ready   = !full[wr_bank];
    assign bus.m_valid   = full[rd_bank];
    assign bus.frame_err = frame_err_q;
    assign bus.frame_cnt = frame_cnt_q;

    assign accept      = bus.s_valid & !full[wr_bank];
    assign handoff     = full[rd_bank] & bus.m_ready;
    assign frame_done  = accept & (wr_idx == 4'd15);
    // s_last early: the partial frame is thrown away and filling restarts at index 0
    assign short_frame = accept & bus.s_last & (wr_idx != 4'd15);
    // s_last missing on index 15: the frame is still delivered, and the error is flagged
    assign long_frame  = frame_done & !bus.s_last;

    // Combine the completion and the handoff into the next bank-full flags.
    // The two can never target the same bank, because a full bank blocks writes.
    always_comb begin
        full_nxt = full;
        if (handoff) begin
            full_nxt[rd_bank] = 1'b0;
        end
        if (frame_done) begin
            full_nxt[wr_bank] = 1'b1;
        end
    end

    // Bank pointers, fill index, handoff counter and the registered error pulse
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_bank     <= 1'b0;
            rd_bank     <= 1'b0;
            full        <= 2'b00;
            wr_idx      <= 4'd0;
            frame_cnt_q <= 8'd0;
            frame_err_q <= 1'b0;
        end else begin
            full        <= full_nxt;
            frame_err_q <= short_frame | long_frame;
            if (frame_done) begin
                wr_bank <= ~wr_bank;
                wr_idx  <= 4'd0;
            end else if (short_frame) begin
                wr_idx  <= 4'd0;
            end else if (accept) begin
                wr_idx  <= wr_idx + 4'd1;
            end
            if (handoff) begin
                rd_bank     <= ~rd_bank;
                frame_cnt_q <= frame_cnt_q + 8'd1;
            end
        end
    end

    // Sample storage. Reset clears it so the idle output buses read zero.
    // Only the bank being filled is written, so a held bank never changes.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int b = 0; b < 2; b++) begin
                for (int k = 0; k < N; k++) begin
                    bank_x[b][k] <= '0;
                    bank_y[b][k] <= '0;
                end
            end
        end else if (accept) begin
            bank_x[wr_bank][wr_idx] <= bus.s_x;
            bank_y[wr_bank][wr_idx] <= bus.s_y;
        end
    end

    // Pack the read bank onto the flat buses that feed the FFT's x_in/y_in ports
    always_comb begin
        bus.m_x = '0;
        bus.m_y = '0;
        for (int k = 0; k < N; k++) begin
            bus.m_x[WIDTH*k +: WIDTH] = bank_x[rd_bank][k];
            bus.m_y[WIDTH*k +: WIDTH] = bank_y[rd_bank][k];
        end
    end
endmodule

// File: tb/tb_fft16_sample_loader.sv
// Scoreboard bench for fft16_sample_loader.
// Completed frames are queued when their last sample is driven.
// Each frame is popped and compared when the DUT hands it off.
module tb_fft16_sample_loader;
    localparam int WIDTH = 16;

    logic clk;
    logic rst_n;

    fft16_sample_loader_if #(.WIDTH(WIDTH)) bus ();

    fft16_sample_loader #(.WIDTH(WIDTH)) dut (
        .clock   (clk),
        .reset_n (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [255:0] x;
        logic [255:0] y;
    } frame_t;

    frame_t       q[$];
    logic [255:0] px;
    logic [255:0] py;
    int           idx;
    logic         err_exp;
    logic [7:0]   cnt_exp;
    int           errors;
    int           checks;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called at a falling edge. It checks the outputs, drives one cycle of inputs,
    // advances the model by whatever will transfer on the next rising edge,
    // and then returns at the following falling edge.
    task automatic step(input logic v, input logic [15:0] x, input logic [15:0] y,
                        input logic l, input logic mr, output logic acc);
        frame_t f;
        logic   ho;
        check("m_valid", bus.m_valid, q.size() != 0);
        check("s_ready", bus.s_ready, q.size() < 2);
        check("frame_err", bus.frame_err, err_exp);
        check("frame_cnt", bus.frame_cnt, cnt_exp);
        bus.s_valid = v;
        bus.s_x     = x;
        bus.s_y     = y;
        bus.s_last  = l;
        bus.m_ready = mr;
        acc = v && bus.s_ready;
        ho  = bus.m_valid && mr;
        if (ho && q.size() > 0) begin
            f = q.pop_front();
            check("m_x", bus.m_x, f.x);
            check("m_y", bus.m_y, f.y);
            cnt_exp = cnt_exp + 8'd1;
        end
        err_exp = 1'b0;
        if (acc) begin
            px[16*idx +: 16] = x;
            py[16*idx +: 16] = y;
            if (idx == 15) begin
                err_exp = !l;
                q.push_back({px, py});
                idx = 0;
            end else if (l) begin
                err_exp = 1'b1;
                idx = 0;
            end else begin
                idx++;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    // Sample j carries x = xbase+j and y = -(xbase+j).
    // last_at = -1 puts s_last on every 16th sample, -2 never asserts it, and any
    // other value asserts it on that sample only.
    // mode 0 holds m_ready low, mode 1 holds it high, and mode 2 randomises valid,
    // ready and data.
    task automatic send_seq(input int n, input int xbase, input int last_at, input int mode);
        int          j;
        int          budget;
        logic        v;
        logic        mr;
        logic        l;
        logic        acc;
        logic [15:0] x;
        logic [15:0] y;
        j = 0;
        budget = 0;
        while (j < n && budget < 10 * n + 100) begin
            v  = (mode == 2) ? ($urandom_range(0, 3) != 0) : 1'b1;
            mr = (mode == 0) ? 1'b0 : (mode == 1) ? 1'b1 : ($urandom_range(0, 2) != 0);
            if (mode == 2) begin
                x = 16'($urandom);
                y = 16'($urandom);
            end else begin
                x = 16'(xbase + j);
                y = 16'(-(xbase + j));
            end
            l = (last_at == -1) ? (j % 16 == 15) : (j == last_at);
            step(v, x, y, l, mr, acc);
            if (acc) j++;
            budget++;
        end
        if (j < n) check("accept_timeout", 256'(j), 256'(n));
    endtask

    task automatic idle(input int n, input logic mr);
        logic acc;
        for (int i = 0; i < n; i++) step(1'b0, 16'h0, 16'h0, 1'b0, mr, acc);
    endtask

    // Asserts reset at a falling edge and checks the outputs right away.
    // Reset is released on the next falling edge.
    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check("rst_m_valid", bus.m_valid, 1'b0);
        check("rst_s_ready", bus.s_ready, 1'b1);
        check("rst_frame_cnt", bus.frame_cnt, 8'd0);
        check("rst_m_x", bus.m_x, 256'd0);
        q.delete();
        idx     = 0;
        px      = '0;
        py      = '0;
        err_exp = 1'b0;
        cnt_exp = 8'd0;
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
        bus.m_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic acc;
        errors = 0;
        checks = 0;
        rst_n  = 1'b0;
        bus.s_valid = 1'b0;
        bus.s_x     = '0;
        bus.s_y     = '0;
        bus.s_last  = 1'b0;
        bus.m_ready = 1'b0;
        @(negedge clk);
        do_reset();

        // one clean frame, k and -k, consumed as soon as it appears
        send_seq(16, 0, -1, 1);
        idle(3, 1'b1);
        check("cnt_after_first", bus.frame_cnt, 8'd1);

        // back pressure: fill both banks, stall, release one frame, then fill again
        do_reset();
        send_seq(32, 0, -1, 0);
        for (int i = 0; i < 3; i++) begin
            if (q.size() > 0) check("hold_x", bus.m_x, q[0].x);
            step(1'b1, 16'd32, 16'(-32), 1'b0, 1'b0, acc);
        end
        step(1'b1, 16'd32, 16'(-32), 1'b0, 1'b1, acc);
        send_seq(16, 32, -1, 0);
        idle(4, 1'b1);

        // early s_last on index 4, followed by a proper frame of 100..115
        send_seq(5, 50, 4, 1);
        send_seq(16, 100, -1, 1);
        idle(3, 1'b1);

        // no s_last at all: the frame is delivered and the error is flagged
        send_seq(16, 300, -2, 1);
        idle(3, 1'b1);

        // reset mid-frame, and reset with a full bank pending
        send_seq(7, 400, -1, 1);
        do_reset();
        send_seq(16, 500, -1, 0);
        send_seq(3, 600, -1, 0);
        do_reset();
        send_seq(16, 200, -1, 1);
        idle(3, 1'b1);

        // random traffic over 300 frames, so frame_cnt wraps past 255
        do_reset();
        send_seq(300 * 16, 0, -1, 2);
        idle(8, 1'b1);
        check("final_cnt", bus.frame_cnt, 8'd44);
        check("final_m_valid", bus.m_valid, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
